// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding,
// RV32I load/store funct3 codes and the all-lanes byte-enable mask.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/lsu_extend.sv
// Load data extractor: picks the addressed byte/halfword out of the bus
// word and sign- or zero-extends it according to funct3. Unknown codes
// return the full word.
module lsu_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] ext
);

    logic        [7:0]  byte_sel;
    logic        [15:0] half_sel;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    // Lane selection followed by size/sign extension
    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        byte_s   = signed'(byte_sel);
        half_s   = signed'(half_sel);
        case (funct3)
            F3_B:    ext = 32'(byte_s);
            F3_BU:   ext = {24'b0, byte_sel};
            F3_H:    ext = 32'(half_s);
            F3_HU:   ext = {16'b0, half_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one aligned access per Start on a req/gnt/rvalid bus,
// stalling the core until Done. Loads time out after TIMEOUT cycles in
// WAIT. Optional macro LSU_MISALIGN_EXC_EN: misaligned halfword/word
// accesses complete immediately with MisalignErr instead of truncating.
module lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Done,
    output logic        Stall,
    output logic        BusErr,
    output logic        MisalignErr,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [3:0]  BusBe,
    output logic [31:0] BusWData,
    input  logic        BusGnt,
    input  logic        BusRValid,
    input  logic [31:0] BusRData
);

    lsu_state_t       state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             buserr_q;
    logic             miserr_q;
    logic [31:0]      ext_data;
    logic             mis_start;
    logic             timeout;
    logic             req;

    // Store byte enables: lane-shifted for bytes/halves, all lanes for words
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return BE_ALL;
        endcase
    endfunction

    // Store data replicated across every lane the access may hit
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

`ifdef LSU_MISALIGN_EXC_EN
    assign mis_start = ((Funct3[1:0] == 2'b01) && Addr[0]) ||
                       ((Funct3[1:0] >= 2'b10) && (Addr[1:0] != 2'b00));
`else
    assign mis_start = 1'b0;
`endif

    assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

    lsu_extend u_extend (
        .rdata   (BusRData),
        .funct3  (f3_q),
        .addr_lo (addr_q[1:0]),
        .ext     (ext_data)
    );

    // State, request latches, timeout counter and held results
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            we_q     <= 1'b0;
            f3_q     <= 3'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            rdata_q  <= 32'b0;
            buserr_q <= 1'b0;
            miserr_q <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (Start) begin
                    we_q     <= MemWrite;
                    f3_q     <= Funct3;
                    addr_q   <= Addr;
                    wdata_q  <= WriteData;
                    rdata_q  <= 32'b0;
                    buserr_q <= 1'b0;
                    miserr_q <= mis_start;
                end
                REQ: if (BusGnt) cnt <= '0;
                WAIT: begin
                    if (BusRValid)    rdata_q  <= ext_data;
                    else if (timeout) buserr_q <= 1'b1;
                    else              cnt      <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Next-state selection
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (Start) state_n = mis_start ? DONE : REQ;
            REQ:  if (BusGnt) state_n = we_q ? DONE : WAIT;
            WAIT: if (BusRValid || timeout) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bus and core-facing outputs, driven only while the request is live
    always_comb begin
        req         = (state == REQ);
        BusReq      = req;
        BusWe       = req && we_q;
        BusAddr     = req ? {addr_q[31:2], 2'b00} : 32'b0;
        BusBe       = req ? (we_q ? store_be(f3_q, addr_q[1:0]) : BE_ALL) : 4'b0;
        BusWData    = (req && we_q) ? store_data(f3_q, wdata_q) : 32'b0;
        Done        = (state == DONE);
        Stall       = (Start && state == IDLE) || state == REQ || state == WAIT;
        ReadData    = rdata_q;
        BusErr      = buserr_q;
        MisalignErr = miserr_q;
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu against a transaction-level reference model.
module tb_lsu;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Done;
    logic        Stall;
    logic        BusErr;
    logic        MisalignErr;
    logic        BusReq;
    logic        BusWe;
    logic [31:0] BusAddr;
    logic [3:0]  BusBe;
    logic [31:0] BusWData;
    logic        BusGnt;
    logic        BusRValid;
    logic [31:0] BusRData;

    int n_chk = 0;
    int n_err = 0;

    lsu #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MemWrite(MemWrite),
        .Funct3(Funct3), .Addr(Addr), .WriteData(WriteData),
        .ReadData(ReadData), .Done(Done), .Stall(Stall), .BusErr(BusErr),
        .MisalignErr(MisalignErr), .BusReq(BusReq), .BusWe(BusWe),
        .BusAddr(BusAddr), .BusBe(BusBe), .BusWData(BusWData),
        .BusGnt(BusGnt), .BusRValid(BusRValid), .BusRData(BusRData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction. g = cycles the grant is withheld, rv = WAIT cycles
    // before read data arrives (rv >= TIMEOUT means it never arrives).
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int g, input int rv);
        int          size;      // bytes in the access
        int          b;
        bit          mis;
        int          done_c;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        logic        e_err;
        logic [31:0] v;
        b    = int'(addr[1:0]);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis  = 0;
`ifdef LSU_MISALIGN_EXC_EN
        mis = (addr % size) != 0;
`endif
        if (!we)            e_be = 4'hF;
        else if (size == 1) e_be = 4'(1 << b);
        else if (size == 2) e_be = (b >= 2) ? 4'hC : 4'h3;
        else                e_be = 4'hF;
        if (size == 1)      e_wd = {4{wd[7:0]}};
        else if (size == 2) e_wd = {2{wd[15:0]}};
        else                e_wd = wd;
        if (size == 1) begin
            v = (rd >> (8 * b)) & 32'hFF;
            if (!f3[2] && v >= 128) v = v - 256;
        end else if (size == 2) begin
            v = (rd >> (16 * (b / 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32768) v = v - 65536;
        end else begin
            v = rd;
        end
        e_err = 1'b0;
        if (mis) begin
            done_c = 1; e_rd = 0;
        end else if (we) begin
            done_c = 2 + g; e_rd = 0;
        end else if (rv < TIMEOUT) begin
            done_c = 3 + g + rv; e_rd = v;
        end else begin
            done_c = 2 + g + TIMEOUT; e_rd = 0; e_err = 1'b1;
        end

        @(posedge clk); #1;
        Start = 1'b1; MemWrite = we; Funct3 = f3; Addr = addr; WriteData = wd;
        BusGnt = 1'b0; BusRValid = 1'b0; BusRData = $urandom;
        @(negedge clk);
        check("stall_c0", 32'(Stall), 1);
        check("done_c0", 32'(Done), 0);
        check("req_c0", 32'(BusReq), 0);
        for (int c = 1; c <= done_c + 1; c++) begin
            @(posedge clk); #1;
            Start     = (c <= done_c) ? 1'($urandom_range(0, 1)) : 1'b0;
            MemWrite  = 1'($urandom);
            Funct3    = 3'($urandom);
            Addr      = $urandom;
            WriteData = $urandom;
            BusGnt    = !mis && (c == 1 + g);
            BusRValid = !we && !mis && (rv < TIMEOUT) && (c == 2 + g + rv);
            BusRData  = BusRValid ? rd : $urandom;
            @(negedge clk);
            check("busreq", 32'(BusReq), 32'(!mis && c <= 1 + g));
            check("stall", 32'(Stall), 32'(c < done_c));
            check("done", 32'(Done), 32'(c == done_c));
            if (!mis && c <= 1 + g) begin
                check("busaddr", BusAddr, {addr[31:2], 2'b00});
                check("busbe", 32'(BusBe), 32'(e_be));
                check("buswe", 32'(BusWe), 32'(we));
                if (we) check("buswdata", BusWData, e_wd);
            end
            if (c >= done_c) begin
                check("readdata", ReadData, e_rd);
                check("buserr", 32'(BusErr), 32'(e_err));
                check("misalign", 32'(MisalignErr), 32'(mis));
            end
        end
        BusGnt = 1'b0; BusRValid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; Start = 1'b0; MemWrite = 1'b0; Funct3 = 3'b0; Addr = 32'b0;
        WriteData = 32'b0; BusGnt = 1'b0; BusRValid = 1'b0; BusRData = 32'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_done", 32'(Done), 0);
        check("rst_stall", 32'(Stall), 0);
        check("rst_req", 32'(BusReq), 0);
        check("rst_rdata", ReadData, 0);
        check("rst_be", 32'(BusBe), 0);
        #1 reset = 1'b0;

        // Directed cases
        run_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);         // SW
        run_txn(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0);         // SB
        run_txn(1'b0, 3'b000, 32'h102, 32'h0, 32'h0080FF00, 0, 0);          // LB
        run_txn(1'b0, 3'b100, 32'h102, 32'h0, 32'h0080FF00, 0, 0);          // LBU
        run_txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h0080FF00, 0, 0);          // LHU
        run_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001FFFF, 1, 0);          // LH
        run_txn(1'b0, 3'b010, 32'h200, 32'h0, 32'h12345678, 3, 1);          // LW slow
        run_txn(1'b0, 3'b010, 32'h204, 32'h0, 32'hCAFEF00D, 0, TIMEOUT);    // timeout
        run_txn(1'b0, 3'b010, 32'h208, 32'h0, 32'h0BADBEEF, 0, TIMEOUT - 1);// last-cycle data
        run_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h55AA55AA, 0, 0);          // misaligned LW
        run_txn(1'b1, 3'b001, 32'h303, 32'h0000BEEF, 32'h0, 2, 0);          // SH odd addr

        // Reset mid-access: abort in WAIT, then a late RValid is ignored
        @(posedge clk); #1;
        Start = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h400; BusGnt = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        @(posedge clk); #1;
        BusGnt = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_stall_before", 32'(Stall), 1);
        @(posedge clk); #1;
        reset = 1'b0; BusRValid = 1'b1; BusRData = 32'h11112222;
        @(negedge clk);
        check("midrst_stall", 32'(Stall), 0);
        check("midrst_req", 32'(BusReq), 0);
        check("midrst_done", 32'(Done), 0);
        check("midrst_rdata", ReadData, 0);
        check("midrst_err", 32'(BusErr), 0);
        @(posedge clk); #1;
        BusRValid = 1'b0;
        @(negedge clk);
        check("late_rvalid_done", 32'(Done), 0);
        check("late_rvalid_rdata", ReadData, 0);

        // Random transactions
        for (int i = 0; i < 60; i++) begin
            int rv;
            rv = ($urandom_range(0, 7) == 0) ? TIMEOUT - int'($urandom_range(0, 1))
                                             : int'($urandom_range(0, 3));
            run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), rv);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
